// File: rtl/store_unit.sv
// rtl/store_unit.sv - two-entry store buffer with lane formatting, alignment fault and load-hazard check
module store_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [2:0]  st_funct3,
    output logic        st_fault,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] ld_check_addr,
    output logic        ld_hazard,
    output logic        empty
);
    typedef enum logic {IDLE, REQ} state_t;

    state_t      state;
    logic [29:0] q_addr [2];
    logic [3:0]  q_be   [2];
    logic [31:0] q_data [2];
    logic        head, tail;
    logic [1:0]  count;

    logic        legal;
    logic [3:0]  new_be;
    logic [31:0] new_data;
    logic        push, pop;
    logic [29:0] ld_word;

    always_comb begin
        legal    = 1'b0;
        new_be   = 4'b0000;
        new_data = st_data;
        case (st_funct3)
            3'b000: begin
                legal    = 1'b1;
                new_be   = 4'b0001 << st_addr[1:0];
                new_data = {4{st_data[7:0]}};
            end
            3'b001: begin
                legal    = ~st_addr[0];
                new_be   = st_addr[1] ? 4'b1100 : 4'b0011;
                new_data = {2{st_data[15:0]}};
            end
            3'b010: begin
                legal    = (st_addr[1:0] == 2'b00);
                new_be   = 4'b1111;
            end
            default: legal = 1'b0;
        endcase
    end

    assign st_ready = ~rst && (count != 2'd2);
    assign push     = st_valid && st_ready && legal;
    assign pop      = (state == REQ) && mem_ack;
    assign empty    = (count == 2'd0) && (state == IDLE);

    // The in-flight store is still the head entry, so the FIFO check covers it;
    // the mem_addr term keeps the hazard visible regardless of pointer timing.
    assign ld_word   = ld_check_addr[31:2];
    assign ld_hazard = (mem_req && mem_addr[31:2] == ld_word)
                    || (count != 2'd0 && q_addr[head] == ld_word)
                    || (count == 2'd2 && q_addr[~head] == ld_word);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            head      <= 1'b0;
            tail      <= 1'b0;
            count     <= 2'd0;
            st_fault  <= 1'b0;
            mem_req   <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            mem_be    <= 4'd0;
        end else begin
            st_fault <= st_valid && st_ready && ~legal;
            if (push) begin
                q_addr[tail] <= st_addr[31:2];
                q_be[tail]   <= new_be;
                q_data[tail] <= new_data;
                tail         <= ~tail;
            end
            if (pop)
                head <= ~head;
            count <= count + {1'b0, push} - {1'b0, pop};

            case (state)
                IDLE: begin
                    if (count != 2'd0) begin
                        state     <= REQ;
                        mem_req   <= 1'b1;
                        mem_addr  <= {q_addr[head], 2'b00};
                        mem_be    <= q_be[head];
                        mem_wdata <= q_data[head];
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        // With one entry left, a same-cycle push lands at ~head and is issued directly.
                        if (count == 2'd2) begin
                            mem_addr  <= {q_addr[~head], 2'b00};
                            mem_be    <= q_be[~head];
                            mem_wdata <= q_data[~head];
                        end else if (push) begin
                            mem_addr  <= {st_addr[31:2], 2'b00};
                            mem_be    <= new_be;
                            mem_wdata <= new_data;
                        end else begin
                            state   <= IDLE;
                            mem_req <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_store_unit.sv
// tb/tb_store_unit.sv - directed self-checking bench for store_unit
module tb_store_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [2:0]  st_funct3;
    logic        st_fault;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] ld_check_addr;
    logic        ld_hazard;
    logic        empty;

    int total = 0;
    int bad   = 0;

    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];

    store_unit dut (
        .clk(clk), .rst(rst), .st_valid(st_valid), .st_ready(st_ready),
        .st_addr(st_addr), .st_data(st_data), .st_funct3(st_funct3),
        .st_fault(st_fault), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
        .ld_check_addr(ld_check_addr), .ld_hazard(ld_hazard), .empty(empty)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (!rst && mem_req && mem_ack) begin
            log_addr.push_back(mem_addr);
            log_data.push_back(mem_wdata);
        end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        st_valid  = 1'b1;
        st_funct3 = f3;
        st_addr   = a;
        st_data   = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
        total++; if (st_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_in_rst got=%b exp=0", st_ready); end
        total++; if ({mem_addr, mem_wdata, mem_be, st_fault} !== 69'd0) begin bad++; $display("FAIL reset_outputs got=%h/%h/%b/%b exp=0", mem_addr, mem_wdata, mem_be, st_fault); end
        rst = 1'b0;
        #1;
        total++; if (st_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_after got=%b exp=1", st_ready); end
    endtask

    task automatic test_sb();
        drive_store(3'b000, 32'h0000_1003, 32'h0000_00A5);
        step();
        st_valid = 1'b0;
        total++; if (mem_req !== 1'b0 || empty !== 1'b0) begin bad++; $display("FAIL sb_accept got req=%b empty=%b exp req=0 empty=0", mem_req, empty); end
        step();
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL sb_req got=%b exp=1", mem_req); end
        total++; if (mem_addr !== 32'h1000 || mem_be !== 4'b1000 || mem_wdata !== 32'hA5A5A5A5) begin
            bad++; $display("FAIL sb_fmt got=%h/%b/%h exp=00001000/1000/a5a5a5a5", mem_addr, mem_be, mem_wdata); end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        total++; if (mem_req !== 1'b0 || empty !== 1'b1) begin bad++; $display("FAIL sb_retire got req=%b empty=%b exp 0/1", mem_req, empty); end
        // byte at lane 1
        drive_store(3'b000, 32'h0000_0201, 32'hFFFF_FF3C);
        step(); st_valid = 1'b0; step();
        total++; if (mem_be !== 4'b0010 || mem_wdata !== 32'h3C3C3C3C || mem_addr !== 32'h200) begin
            bad++; $display("FAIL sb_lane1 got=%h/%b/%h exp=00000200/0010/3c3c3c3c", mem_addr, mem_be, mem_wdata); end
        mem_ack = 1'b1; step(); mem_ack = 1'b0;
    endtask

    task automatic test_sh_and_faults();
        drive_store(3'b001, 32'h0000_2002, 32'h1234_BEEF);
        step(); st_valid = 1'b0; step();
        total++; if (mem_req !== 1'b1 || mem_be !== 4'b1100 || mem_wdata !== 32'hBEEFBEEF || mem_addr !== 32'h2000) begin
            bad++; $display("FAIL sh_fmt got=%b/%h/%b/%h exp=1/00002000/1100/beefbeef", mem_req, mem_addr, mem_be, mem_wdata); end
        mem_ack = 1'b1; step(); mem_ack = 1'b0;
        drive_store(3'b001, 32'h0000_2001, 32'h1234_BEEF);
        step(); st_valid = 1'b0;
        total++; if (st_fault !== 1'b1 || empty !== 1'b1) begin bad++; $display("FAIL sh_mis_fault got fault=%b empty=%b exp 1/1", st_fault, empty); end
        step();
        total++; if (st_fault !== 1'b0 || mem_req !== 1'b0 || empty !== 1'b1) begin
            bad++; $display("FAIL sh_mis_after got fault=%b req=%b empty=%b exp 0/0/1", st_fault, mem_req, empty); end
        drive_store(3'b010, 32'h0000_3002, 32'h1);
        step(); st_valid = 1'b0;
        total++; if (st_fault !== 1'b1) begin bad++; $display("FAIL sw_mis_fault got=%b exp=1", st_fault); end
        drive_store(3'b011, 32'h0000_3000, 32'h1);
        step(); st_valid = 1'b0;
        total++; if (st_fault !== 1'b1 || empty !== 1'b1) begin bad++; $display("FAIL bad_width_fault got fault=%b empty=%b exp 1/1", st_fault, empty); end
        step();
        total++; if (st_fault !== 1'b0 || mem_req !== 1'b0) begin bad++; $display("FAIL bad_width_after got fault=%b req=%b exp 0/0", st_fault, mem_req); end
    endtask

    task automatic test_back_to_back();
        log_addr.delete(); log_data.delete();
        drive_store(3'b010, 32'h10, 32'hAAAA_0010);
        step();
        drive_store(3'b010, 32'h14, 32'hAAAA_0014);
        step();
        total++; if (st_ready !== 1'b0) begin bad++; $display("FAIL fifo_full_ready got=%b exp=0", st_ready); end
        drive_store(3'b010, 32'h18, 32'hAAAA_0018);
        step();
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h10 || st_ready !== 1'b0) begin
            bad++; $display("FAIL fifo_stall got req=%b addr=%h ready=%b exp 1/00000010/0", mem_req, mem_addr, st_ready); end
        mem_ack = 1'b1;
        step();
        total++; if (mem_addr !== 32'h14 || st_ready !== 1'b1) begin bad++; $display("FAIL fifo_second got addr=%h ready=%b exp 00000014/1", mem_addr, st_ready); end
        step();
        st_valid = 1'b0;
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h18 || mem_wdata !== 32'hAAAA0018) begin
            bad++; $display("FAIL fifo_third got req=%b addr=%h data=%h exp 1/00000018/aaaa0018", mem_req, mem_addr, mem_wdata); end
        step();
        mem_ack = 1'b0;
        total++; if (mem_req !== 1'b0 || empty !== 1'b1) begin bad++; $display("FAIL fifo_drain got req=%b empty=%b exp 0/1", mem_req, empty); end
        total++; if (log_addr.size() != 3) begin bad++; $display("FAIL fifo_count got=%0d exp=3", log_addr.size()); end
        else if (log_addr[0] !== 32'h10 || log_addr[1] !== 32'h14 || log_addr[2] !== 32'h18 || log_data[2] !== 32'hAAAA0018) begin
            bad++; $display("FAIL fifo_order got=%h,%h,%h exp=10,14,18", log_addr[0], log_addr[1], log_addr[2]); end
    endtask

    task automatic test_hazard();
        drive_store(3'b010, 32'h40, 32'h5);
        step();
        st_valid = 1'b0;
        ld_check_addr = 32'h43; #1;
        total++; if (ld_hazard !== 1'b1) begin bad++; $display("FAIL hz_buffered got=%b exp=1", ld_hazard); end
        ld_check_addr = 32'h44; #1;
        total++; if (ld_hazard !== 1'b0) begin bad++; $display("FAIL hz_other_word got=%b exp=0", ld_hazard); end
        step();
        ld_check_addr = 32'h43; #1;
        total++; if (ld_hazard !== 1'b1 || mem_req !== 1'b1) begin bad++; $display("FAIL hz_inflight got hz=%b req=%b exp 1/1", ld_hazard, mem_req); end
        mem_ack = 1'b1; step(); mem_ack = 1'b0; #1;
        total++; if (ld_hazard !== 1'b0 || empty !== 1'b1) begin bad++; $display("FAIL hz_retired got hz=%b empty=%b exp 0/1", ld_hazard, empty); end
        ld_check_addr = 32'h0;
    endtask

    task automatic test_reset_in_req();
        drive_store(3'b010, 32'h80, 32'h80);
        step();
        drive_store(3'b010, 32'h84, 32'h84);
        step();
        st_valid = 1'b0;
        total++; if (mem_req !== 1'b1 || st_ready !== 1'b0) begin bad++; $display("FAIL rr_setup got req=%b ready=%b exp 1/0", mem_req, st_ready); end
        rst = 1'b1;
        step();
        total++; if (mem_req !== 1'b0 || empty !== 1'b1) begin bad++; $display("FAIL rr_flush got req=%b empty=%b exp 0/1", mem_req, empty); end
        rst = 1'b0; #1;
        total++; if (st_ready !== 1'b1) begin bad++; $display("FAIL rr_ready got=%b exp=1", st_ready); end
        log_addr.delete(); log_data.delete();
        mem_ack = 1'b1;
        repeat (5) step();
        mem_ack = 1'b0;
        total++; if (log_addr.size() != 0 || mem_req !== 1'b0) begin bad++; $display("FAIL rr_no_writes got writes=%0d req=%b exp 0/0", log_addr.size(), mem_req); end
    endtask

    initial begin
        rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_funct3 = '0;
        mem_ack = 1'b0; ld_check_addr = '0;
        #1;
        test_reset();
        test_sb();
        test_sh_and_faults();
        test_back_to_back();
        test_hazard();
        test_reset_in_req();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/store_unit.md
STORE_UNIT -- requirements
Module: store_unit

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 st_valid  input  1  execute stage presents a store.
REQ-004 st_ready  output  1  unit can accept a store this cycle.
REQ-005 st_addr  input  32  byte address of the store.
REQ-006 st_data  input  32  rs2 value; low bits hold the byte/half for narrow stores.
REQ-007 st_funct3  input  3  store width: SB=000, SH=001, SW=010.
REQ-008 st_fault  output  1  one-cycle pulse: misaligned or illegal-width store was dropped.
REQ-009 mem_req  output  1  write request to data memory.
REQ-010 mem_addr  output  32  word address, bits [1:0] always 0.
REQ-011 mem_wdata  output  32  lane-replicated write data.
REQ-012 mem_be  output  4  byte enables; bit i enables byte lane i (bits 8i+7:8i).
REQ-013 mem_ack  input  1  memory accepted the current request.
REQ-014 ld_check_addr  input  32  address of a load in the pipeline.
REQ-015 ld_hazard  output  1  a buffered store overlaps the load's word.
REQ-016 empty  output  1  no buffered or in-flight store.

Function
REQ-017 The unit SHALL hold a 2-entry FIFO of {word address, be, wdata}, with a count of 0..2 and wrapping head/tail pointers.
REQ-018 st_ready SHALL be 1 when count<2 and rst=0, else 0; there is no same-cycle bypass of a pop when the FIFO is full.
REQ-019 A handshake (st_valid & st_ready) SHALL consume the store in that cycle.
REQ-020 Alignment: SB is legal at any address; SH is legal when addr[0]=0; SW is legal when addr[1:0]=00; any other funct3 is illegal.
REQ-021 An illegal or misaligned handshake SHALL NOT be enqueued; st_fault SHALL be 1 in the following cycle only.
REQ-022 SB SHALL produce be=0001<<addr[1:0] and wdata={4{data[7:0]}}.
REQ-023 SH SHALL produce be=0011 when addr[1]=0 or 1100 when addr[1]=1, and wdata={2{data[15:0]}}.
REQ-024 SW SHALL produce be=1111 and wdata=data.
REQ-025 The FSM SHALL have two states, IDLE and REQ.
REQ-026 IDLE: mem_req=0; on the next edge with count>0, the FSM SHALL move to REQ and load mem_addr/mem_be/mem_wdata from the head entry.
REQ-027 REQ: mem_req=1 and the outputs SHALL stay stable until mem_ack.
REQ-028 On mem_ack in REQ, the head entry SHALL be popped.
REQ-029 After that pop, the FSM SHALL stay in REQ with the next entry on the following cycle if entries remain (back-to-back), else return to IDLE.
REQ-030 Latency: a store accepted into an empty unit at edge N SHALL show mem_req=1 after edge N+1; with mem_ack held high, the throughput SHALL be 1 store/cycle.
REQ-031 mem_ack while mem_req=0 SHALL be ignored.
REQ-032 A simultaneous enqueue and pop SHALL leave count unchanged, with both operations taking effect.
REQ-033 ld_hazard SHALL be combinational: 1 iff any valid entry, or the entry in flight, has word address == ld_check_addr[31:2].
REQ-034 empty SHALL be 1 iff count=0 and the FSM is in IDLE.

Reset
REQ-035 With rst=1 at an edge, the unit SHALL clear count and pointers, enter IDLE, clear mem_req/mem_addr/mem_wdata/mem_be/st_fault to 0, and set empty=1.
REQ-036 st_ready SHALL be 0 while rst=1.
REQ-037 Reset during REQ SHALL discard all entries without waiting for mem_ack; mem_req SHALL be 0 after that edge.

Verification
REQ-038 SB addr=0x1003, data=0x000000A5 -> next cycle mem_req=1, mem_addr=0x1000, mem_be=1000, mem_wdata=0xA5A5A5A5.
REQ-039 SH addr=0x2002, data=0x1234BEEF -> mem_be=1100, mem_wdata=0xBEEFBEEF; SH addr=0x2001 -> st_fault pulse, no mem_req, empty stays 1.
REQ-040 Three SW stores to 0x10/0x14/0x18 with mem_ack held low -> st_ready=0 after two; raising mem_ack drains them in order with the third accepted; writes occur in issue order.
REQ-041 Buffer SW 0x40 and probe ld_check_addr=0x43 -> ld_hazard=1; probe 0x44 -> ld_hazard=0; after the ack retires the store -> ld_hazard=0.
REQ-042 Assert rst while in REQ with 2 entries -> next cycle mem_req=0, empty=1, st_ready=1 once rst=0, and no further writes are issued.
